// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: ID/EX hazard inputs and front-end pipeline controls.
// master drives the pipeline status; slave is the hazard controller.
interface hazard_ctrl_if;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_UsesRt;
  logic        ID_MultiCycle;
  logic        EX_MemRead;
  logic [4:0]  EX_Rt;
  logic        EX_BranchTaken;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IFIDFlush;
  logic        IDEXBubble;
  logic [15:0] StallCycles;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_MultiCycle, EX_MemRead, EX_Rt, EX_BranchTaken,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, StallCycles
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_MultiCycle, EX_MemRead, EX_Rt, EX_BranchTaken,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, StallCycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Front-end hazard controller: load-use, multi-cycle ID op and taken-branch sequencing.
// Define HAZARD_STATS_EN to build the saturating StallCycles counter; otherwise it reads 0.
module hazard_ctrl #(
  parameter int unsigned MC_CYCLES = 4,
  parameter int unsigned CNT_W     = 3
) (
  input logic         Clk,
  input logic         Rst_n,
  hazard_ctrl_if.slave hif
);

  typedef enum logic [1:0] {StRun, StMcStall, StMcRelease} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               load_use;
  logic               pc_write, ifid_write, ifid_flush, idex_bubble;

  // $0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use = hif.EX_MemRead && (hif.EX_Rt != 5'd0) &&
                    ((hif.EX_Rt == hif.ID_Rs) || (hif.ID_UsesRt && (hif.EX_Rt == hif.ID_Rt)));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!Rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = StRun;
      cnt_d       = '0;
    end else if (hif.EX_BranchTaken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = StRun;
      cnt_d       = '0;
    end else if (load_use) begin
      // State and count hold, so the stall ends by itself once the load leaves EX.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (hif.ID_MultiCycle) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (MC_CYCLES == 1) begin
              state_d = StMcRelease;
              cnt_d   = '0;
            end else begin
              state_d = StMcStall;
              cnt_d   = CNT_W'(MC_CYCLES - 1);
            end
          end
        end
        StMcStall: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = StMcRelease;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StMcRelease: state_d = StRun;
        default: begin
          state_d = StRun;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign hif.PCWrite    = pc_write;
  assign hif.IFIDWrite  = ifid_write;
  assign hif.IFIDFlush  = ifid_flush;
  assign hif.IDEXBubble = idex_bubble;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q <= 16'd0;
    end else if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign hif.StallCycles = stall_cnt_q;
`else
  assign hif.StallCycles = 16'd0;
`endif

endmodule
